sha256_round_driver: RTL and testbench

//  Drives the e/f/g operands of the Ch bit-select function: it is the producer that

---
 rtl/sha256_round_driver.sv | 175 +++++++++++++++++
 tb/tb_sha256_round_driver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_driver.sv
// SHA-256 compression round engine: owns working variables a..h, runs one round per
// accepted W word, then folds the chaining value back in to produce the block digest.
module sha256_round_driver #(
  parameter int ROUNDS = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [255:0] i_h_in,
  input  logic         i_w_valid,
  input  logic [31:0]  i_w_data,
  output logic         o_w_ready,
  output logic         o_busy,
  output logic [5:0]   o_round_idx,
  output logic         o_digest_valid,
  output logic [255:0] o_digest
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [31:0]  r_var [8];
  logic [31:0]  r_h   [8];
  logic [5:0]   r_t;
  logic         r_busy;
  logic         r_digest_valid;
  logic [255:0] r_digest;

  logic [31:0]  w_h_word [8];
  logic [31:0]  w_sum    [8];
  logic [255:0] w_digest_next;
  logic         w_fire;
  logic         w_last;
  logic [31:0]  w_s0, w_s1, w_ch, w_maj, w_t1, w_t2, w_k;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    case (idx)
      6'd0:  k_rom = 32'h428a2f98;  6'd1:  k_rom = 32'h71374491;
      6'd2:  k_rom = 32'hb5c0fbcf;  6'd3:  k_rom = 32'he9b5dba5;
      6'd4:  k_rom = 32'h3956c25b;  6'd5:  k_rom = 32'h59f111f1;
      6'd6:  k_rom = 32'h923f82a4;  6'd7:  k_rom = 32'hab1c5ed5;
      6'd8:  k_rom = 32'hd807aa98;  6'd9:  k_rom = 32'h12835b01;
      6'd10: k_rom = 32'h243185be;  6'd11: k_rom = 32'h550c7dc3;
      6'd12: k_rom = 32'h72be5d74;  6'd13: k_rom = 32'h80deb1fe;
      6'd14: k_rom = 32'h9bdc06a7;  6'd15: k_rom = 32'hc19bf174;
      6'd16: k_rom = 32'he49b69c1;  6'd17: k_rom = 32'hefbe4786;
      6'd18: k_rom = 32'h0fc19dc6;  6'd19: k_rom = 32'h240ca1cc;
      6'd20: k_rom = 32'h2de92c6f;  6'd21: k_rom = 32'h4a7484aa;
      6'd22: k_rom = 32'h5cb0a9dc;  6'd23: k_rom = 32'h76f988da;
      6'd24: k_rom = 32'h983e5152;  6'd25: k_rom = 32'ha831c66d;
      6'd26: k_rom = 32'hb00327c8;  6'd27: k_rom = 32'hbf597fc7;
      6'd28: k_rom = 32'hc6e00bf3;  6'd29: k_rom = 32'hd5a79147;
      6'd30: k_rom = 32'h06ca6351;  6'd31: k_rom = 32'h14292967;
      6'd32: k_rom = 32'h27b70a85;  6'd33: k_rom = 32'h2e1b2138;
      6'd34: k_rom = 32'h4d2c6dfc;  6'd35: k_rom = 32'h53380d13;
      6'd36: k_rom = 32'h650a7354;  6'd37: k_rom = 32'h766a0abb;
      6'd38: k_rom = 32'h81c2c92e;  6'd39: k_rom = 32'h92722c85;
      6'd40: k_rom = 32'ha2bfe8a1;  6'd41: k_rom = 32'ha81a664b;
      6'd42: k_rom = 32'hc24b8b70;  6'd43: k_rom = 32'hc76c51a3;
      6'd44: k_rom = 32'hd192e819;  6'd45: k_rom = 32'hd6990624;
      6'd46: k_rom = 32'hf40e3585;  6'd47: k_rom = 32'h106aa070;
      6'd48: k_rom = 32'h19a4c116;  6'd49: k_rom = 32'h1e376c08;
      6'd50: k_rom = 32'h2748774c;  6'd51: k_rom = 32'h34b0bcb5;
      6'd52: k_rom = 32'h391c0cb3;  6'd53: k_rom = 32'h4ed8aa4a;
      6'd54: k_rom = 32'h5b9cca4f;  6'd55: k_rom = 32'h682e6ff3;
      6'd56: k_rom = 32'h748f82ee;  6'd57: k_rom = 32'h78a5636f;
      6'd58: k_rom = 32'h84c87814;  6'd59: k_rom = 32'h8cc70208;
      6'd60: k_rom = 32'h90befffa;  6'd61: k_rom = 32'ha4506ceb;
      6'd62: k_rom = 32'hbef9a3f7;  6'd63: k_rom = 32'hc67178f2;
      default: k_rom = 32'h0;
    endcase
  endfunction

  // Word 0 (a / H0) lives in the top 32 bits of the 256-bit buses.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_words
      assign w_h_word[gi] = i_h_in[255-32*gi -: 32];
      assign w_sum[gi]    = r_h[gi] + r_var[gi];
    end
  endgenerate

  always_comb begin
    w_digest_next = '0;
    for (int i = 0; i < 8; i++) begin
      w_digest_next[255-32*i -: 32] = w_sum[i];
    end
  end

  assign w_fire = (r_state == S_ROUND) && i_w_valid;
  assign w_last = (r_t == 6'(ROUNDS - 1));

  always_comb begin
    w_k   = k_rom(r_t);
    w_s1  = ror(r_var[4], 6) ^ ror(r_var[4], 11) ^ ror(r_var[4], 25);
    w_ch  = (r_var[4] & r_var[5]) | (~r_var[4] & r_var[6]);
    w_t1  = r_var[7] + w_s1 + w_ch + w_k + i_w_data;
    w_s0  = ror(r_var[0], 2) ^ ror(r_var[0], 13) ^ ror(r_var[0], 22);
    w_maj = (r_var[0] & r_var[1]) | (r_var[0] & r_var[2]) | (r_var[1] & r_var[2]);
    w_t2  = w_s0 + w_maj;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_ROUND;
      S_ROUND: if (w_fire && w_last) w_state_next = S_FINAL;
      S_FINAL: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_w_ready   = (r_state == S_ROUND);
    o_round_idx = (r_state == S_ROUND) ? r_t : 6'd0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_var[i] <= '0;
        r_h[i]   <= '0;
      end
      r_t            <= '0;
      r_busy         <= 1'b0;
      r_digest_valid <= 1'b0;
      r_digest       <= '0;
    end else begin
      r_busy         <= (w_state_next != S_IDLE);
      r_digest_valid <= (r_state == S_FINAL);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            for (int i = 0; i < 8; i++) begin
              r_var[i] <= w_h_word[i];
              r_h[i]   <= w_h_word[i];
            end
            r_t <= '0;
          end
        end
        S_ROUND: begin
          // A stalled cycle (no valid word) leaves every variable untouched.
          if (w_fire) begin
            r_var[0] <= w_t1 + w_t2;
            r_var[1] <= r_var[0];
            r_var[2] <= r_var[1];
            r_var[3] <= r_var[2];
            r_var[4] <= r_var[3] + w_t1;
            r_var[5] <= r_var[4];
            r_var[6] <= r_var[5];
            r_var[7] <= r_var[6];
            if (!w_last) r_t <= r_t + 6'd1;
          end
        end
        S_FINAL: r_digest <= w_digest_next;
        default: ;
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_digest_valid = r_digest_valid;
  assign o_digest       = r_digest;

endmodule

// File: tb/tb_sha256_round_driver.sv
// Bench for sha256_round_driver: a block-level SHA-256 reference model drives
// per-cycle expectations, with known-answer digests pinning the model.
module tb_sha256_round_driver;

  typedef logic [63:0][31:0] wvec_t;

  logic         clk = 1'b0;
  logic         rst_n, start, w_valid;
  logic [255:0] h_in;
  logic [31:0]  w_data;
  logic         w_ready, busy, digest_valid;
  logic [5:0]   round_idx;
  logic [255:0] digest;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMP_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic [31:0] kt [64];
  wvec_t       w_abc, w_empty;

  always #5 clk = ~clk;

  sha256_round_driver #(.ROUNDS(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_h_in(h_in),
    .i_w_valid(w_valid), .i_w_data(w_data), .o_w_ready(w_ready),
    .o_busy(busy), .o_round_idx(round_idx), .o_digest_valid(digest_valid),
    .o_digest(digest)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic wvec_t expand(input logic [511:0] blk);
    wvec_t w;
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    return w;
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hv, input wvec_t w);
    logic [31:0]  v [8];
    logic [31:0]  t1, t2, bs0, bs1, ch, mj;
    logic [255:0] res;
    for (int i = 0; i < 8; i++) v[i] = hv[255-32*i -: 32];
    for (int r = 0; r < 64; r++) begin
      bs1 = ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25);
      ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
      t1  = v[7] + bs1 + ch + kt[r] + w[r];
      bs0 = ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22);
      mj  = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      t2  = bs0 + mj;
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    res = '0;
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hv[255-32*i -: 32] + v[i];
    return res;
  endfunction

  // Transaction-level model: collects the consumed words of a block and hashes them at the end.
  logic         m_busy, m_in_round, m_dv;
  logic [5:0]   m_t;
  logic [255:0] m_H, m_digest;
  wvec_t        m_w;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_in_round <= 1'b0; m_dv <= 1'b0; m_t <= '0;
      m_H <= '0; m_digest <= '0; m_w <= '0;
    end else begin
      m_dv <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1; m_in_round <= 1'b1; m_t <= '0; m_H <= h_in;
        end
      end else if (m_in_round) begin
        if (w_valid) begin
          m_w[m_t] <= w_data;
          if (m_t == 6'd63) m_in_round <= 1'b0;
          else              m_t <= m_t + 6'd1;
        end
      end else begin
        m_digest <= compress(m_H, m_w);
        m_dv     <= 1'b1;
        m_busy   <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 256'(busy), 256'(m_busy));
      chk("w_ready", 256'(w_ready), 256'(m_in_round));
      chk("round_idx", 256'(round_idx), 256'(m_in_round ? m_t : 6'd0));
      chk("digest_valid", 256'(digest_valid), 256'(m_dv));
      chk("digest", digest, m_digest);
    end
  end

  task automatic run_block(input logic [255:0] hv, input wvec_t w, input int gmax,
                           input bit keep_start, input int abort_at, input int exp_k,
                           input string tag);
    int k;
    int idx;
    bit seen;
    h_in = hv; start = 1'b1; w_valid = 1'b0; k = 0;
    @(negedge clk); k++;
    if (!keep_start) start = 1'b0;
    idx = 0;
    while (idx < 64) begin
      if (idx == abort_at) begin
        rst_n = 1'b0; start = 1'b0; w_valid = 1'b0;
        #1;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_w_ready", 256'(w_ready), 256'(0));
        chk("rst_round_idx", 256'(round_idx), 256'(0));
        chk("rst_digest_valid", 256'(digest_valid), 256'(0));
        chk("rst_digest", digest, 256'(0));
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("rst_no_pulse", 256'(digest_valid), 256'(0));
        end
        rst_n = 1'b1;
        $display("block %s aborted by reset at round %0d", tag, idx);
        return;
      end
      repeat ($urandom_range(0, gmax)) begin
        w_valid = 1'b0; w_data = $urandom; @(negedge clk); k++;
      end
      w_valid = 1'b1; w_data = w[idx];
      @(negedge clk); k++; idx++;
    end
    w_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); k++;
      if (digest_valid) seen = 1'b1;
    end
    chk("digest_valid_seen", 256'(seen), 256'(1));
    if (exp_k > 0) chk("digest_latency", 256'(k), 256'(exp_k));
    $display("block %s: digest=%h after %0d cycles", tag, digest, k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    kt = '{32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
           32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
           32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
           32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
           32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
           32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
           32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
           32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
           32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
           32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
           32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    w_abc   = expand({32'h61626380, 448'h0, 32'h00000018});
    w_empty = expand({32'h80000000, 480'h0});

    rst_n = 1'b0; start = 1'b0; w_valid = 1'b0; h_in = '0; w_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 256'(busy), 256'(0));
    chk("reset_w_ready", 256'(w_ready), 256'(0));
    chk("reset_round_idx", 256'(round_idx), 256'(0));
    chk("reset_digest_valid", 256'(digest_valid), 256'(0));
    chk("reset_digest", digest, 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    chk("model_abc", compress(IV, w_abc), ABC_DIG);
    chk("model_empty", compress(IV, w_empty), EMP_DIG);

    run_block(IV, w_abc, 0, 1'b0, -1, 66, "abc");
    chk("abc_digest", digest, ABC_DIG);

    run_block(IV, w_abc, 5, 1'b0, -1, 0, "abc_gaps");
    chk("abc_gaps_digest", digest, ABC_DIG);

    run_block(IV, w_empty, 0, 1'b0, -1, 66, "empty");
    chk("empty_digest", digest, EMP_DIG);

    run_block(IV, w_abc, 2, 1'b0, 30, 0, "abort");
    chk("abort_digest", digest, 256'(0));
    run_block(IV, w_abc, 0, 1'b0, -1, 66, "abc_after_reset");
    chk("abc_after_reset_digest", digest, ABC_DIG);

    run_block(IV, w_abc, 1, 1'b1, -1, 0, "abc_start_held");
    chk("start_held_digest", digest, ABC_DIG);
    run_block(IV, w_empty, 0, 1'b0, -1, 66, "empty_back_to_back");
    chk("back_to_back_digest", digest, EMP_DIG);

    start = 1'b0; w_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_busy", 256'(busy), 256'(0));
    chk("idle_w_ready", 256'(w_ready), 256'(0));
    chk("idle_digest_hold", digest, EMP_DIG);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
